// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared constants, state encoding and writeback record for the
// multiply/divide issue controller.
package multdiv_issue_ctrl_pkg;

  localparam int MD_REG_W    = 5;
  localparam int MD_EXC_REG  = 30;
  localparam int MD_EXC_MULT = 4;
  localparam int MD_EXC_DIV  = 5;
  localparam int MD_TIMEOUT  = 64;

  // Controller states, 2-bit encoding
  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE  = 2'd0;
  localparam md_state_t ST_START = 2'd1;
  localparam md_state_t ST_BUSY  = 2'd2;
  localparam md_state_t ST_WB    = 2'd3;

  // Writeback record captured when the operation completes
  typedef struct packed {
    logic [MD_REG_W-1:0] rd;
    logic [31:0]         data;
    logic                exc;
  } md_wb_t;

endpackage

// File: rtl/multdiv_timeout_cnt.sv
// Saturating BUSY-cycle counter with synchronous clear and a terminal flag
// that rises when TIMEOUT-1 cycles have been counted.
module multdiv_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles, holding at LAST instead of wrapping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      count <= '0;
    else if (clear)                    count <= '0;
    else if (enable && count != LAST)  count <= count + 1'b1;
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the shared multiply/divide unit: accepts one request,
// pulses start for one cycle, stalls the pipeline until the result (or a
// timeout), then offers a writeback that is redirected to the status register
// on exception.
//
// Handshakes: a request is taken when iss_valid=1 while iss_ready=1 and
// flush=0. A writeback completes in the cycle wb_valid=1 and wb_ready=1;
// wb_rd/wb_data/wb_exc are held stable from wb_valid rising until then.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int REG_W    = MD_REG_W,
  parameter int EXC_REG  = MD_EXC_REG,
  parameter int EXC_MULT = MD_EXC_MULT,
  parameter int EXC_DIV  = MD_EXC_DIV,
  parameter int TIMEOUT  = MD_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             iss_valid,
  input  logic             iss_is_div,
  input  logic [31:0]      iss_a,
  input  logic [31:0]      iss_b,
  input  logic [REG_W-1:0] iss_rd,
  output logic             iss_ready,
  output logic             stall,
  input  logic             flush,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_exc,
  input  logic             wb_ready,
  output logic [1:0]       dbg_state
);

  md_state_t        state, state_nx;
  logic [31:0]      op_a, op_b;
  logic [REG_W-1:0] op_rd;
  logic             op_div;
  md_wb_t           res;

  logic accept, in_start, in_busy, in_wb, terminal;

  assign accept   = (state == ST_IDLE) && iss_valid && !flush;
  assign in_start = (state == ST_START);
  assign in_busy  = (state == ST_BUSY);
  assign in_wb    = (state == ST_WB);

  multdiv_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (in_start),
    .enable   (in_busy),
    .terminal (terminal)
  );

  // Next-state selection; flush abandons any in-flight operation
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_START;
      ST_START: state_nx = flush ? ST_IDLE : ST_BUSY;
      ST_BUSY: begin
        if (flush)
          state_nx = ST_IDLE;
        else if (md_resultRDY)
          // A clean write to r0 has no effect, so skip the writeback
          state_nx = (!md_exception && op_rd == '0) ? ST_IDLE : ST_WB;
        else if (terminal)
          state_nx = ST_WB;
      end
      ST_WB:    if (flush || wb_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Latch the request operands on accept; they stay on md_operandA/B
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_rd  <= '0;
      op_div <= 1'b0;
    end else if (accept) begin
      op_a   <= iss_a;
      op_b   <= iss_b;
      op_rd  <= iss_rd;
      op_div <= iss_is_div;
    end
  end

  // Capture the completion (result, exception or timeout) as a writeback
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res <= '0;
    end else if (in_busy && !flush) begin
      if (md_resultRDY) begin
        res.rd   <= md_exception ? MD_REG_W'(EXC_REG) : MD_REG_W'(op_rd);
        res.data <= md_exception ? (op_div ? 32'(EXC_DIV) : 32'(EXC_MULT)) : md_result;
        res.exc  <= md_exception;
      end else if (terminal) begin
        res.rd   <= MD_REG_W'(EXC_REG);
        res.data <= 32'(EXC_DIV);
        res.exc  <= 1'b1;
      end
    end
  end

  assign iss_ready    = (state == ST_IDLE);
  assign stall        = accept || in_start || in_busy || (in_wb && !wb_ready);
  assign md_ctrl_MULT = in_start && !op_div;
  assign md_ctrl_DIV  = in_start && op_div;
  assign md_operandA  = op_a;
  assign md_operandB  = op_b;
  assign wb_valid     = in_wb;
  assign wb_rd        = in_wb ? REG_W'(res.rd) : '0;
  assign wb_data      = in_wb ? res.data : '0;
  assign wb_exc       = in_wb && res.exc;
  assign dbg_state    = state;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: directed scenarios plus randomized traffic,
// a behavioural multdiv responder, and a transaction-level reference model
// compared against the DUT outputs every falling edge.
module tb_multdiv_issue_ctrl;

  localparam int TIMEOUT = 64;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        iss_valid = 0, iss_is_div = 0, flush = 0, wb_ready = 1;
  logic [31:0] iss_a = 0, iss_b = 0, md_result = 0;
  logic [4:0]  iss_rd = 0;
  logic        md_exception = 0, md_resultRDY = 0;
  logic        iss_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exc;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  dbg_state;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_is_div(iss_is_div), .iss_a(iss_a), .iss_b(iss_b),
    .iss_rd(iss_rd), .iss_ready(iss_ready), .stall(stall), .flush(flush),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
    .wb_ready(wb_ready), .dbg_state(dbg_state)
  );

  // ---------------- counters / observations ----------------
  int vectors = 0, miscompares = 0, cyc_n = 0;
  int pulse_n = 0, pulse_cyc = 0, acc_cyc = 0, hs_n = 0, wbv_n = 0, wb_first = 0;
  logic [31:0] pulse_a = 0, pulse_b = 0, hs_data = 0;
  logic [4:0]  hs_rd = 0;
  logic        hs_exc = 0, prev_wbv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // ---------------- multdiv responder ----------------
  int          stub_lat = 3;     // -1: result never arrives
  logic        stub_mexc = 0;
  logic        stub_pulse = 0, stub_div = 0, stub_armed = 0;
  logic [31:0] stub_a = 0, stub_b = 0, stub_res = 0;
  logic        stub_exc = 0;
  int          stub_cnt = 0;

  // Ready stays high until the next start pulse, like a real unit
  task automatic stub_update();
    if (stub_pulse) begin
      stub_res     = stub_div ? (stub_b == 0 ? 32'd0 : stub_a / stub_b) : stub_a * stub_b;
      stub_exc     = stub_div ? (stub_b == 0) : stub_mexc;
      stub_armed   = (stub_lat >= 0);
      stub_cnt     = stub_lat;
      md_resultRDY = 1'b0;
    end
    if (stub_armed && stub_cnt == 0) begin
      md_resultRDY = 1'b1;
      md_result    = stub_res;
      md_exception = stub_exc;
      stub_armed   = 1'b0;
    end else if (stub_armed) begin
      stub_cnt--;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    stub_update();
  endtask

  // ---------------- reference model ----------------
  // One request in flight at most; m_age counts cycles since it was accepted.
  bit          m_active = 0, m_have = 0, m_div = 0;
  int          m_age = 0, m_busy_n = 0;
  logic [31:0] m_a = 0, m_b = 0, m_wdata = 0;
  logic [4:0]  m_rd = 0, m_wrd = 0;
  bit          m_wexc = 0;

  initial begin
    logic        e_ready, e_stall, e_mult, e_div, e_wbv, e_wexc;
    logic [4:0]  e_wrd;
    logic [31:0] e_wdata, e_opa, e_opb;
    forever begin
      @(negedge clock);
      cyc_n++;
      e_ready = 0; e_stall = 0; e_mult = 0; e_div = 0; e_wbv = 0; e_wexc = 0;
      e_wrd = 0; e_wdata = 0;
      if (!reset_n) begin
        m_active = 0; m_have = 0; m_a = 0; m_b = 0;
        e_ready = 1;
      end else if (!m_active) begin
        e_ready = 1;
        e_stall = iss_valid && !flush;
      end else if (m_have) begin
        e_wbv = 1; e_wrd = m_wrd; e_wdata = m_wdata; e_wexc = m_wexc;
        e_stall = !wb_ready;
      end else begin
        e_stall = 1;
        if (m_age == 1) begin e_div = m_div; e_mult = !m_div; end
      end
      e_opa = m_a; e_opb = m_b;

      chk("iss_ready", iss_ready, e_ready);
      chk("stall", stall, e_stall);
      chk("md_ctrl_MULT", md_ctrl_MULT, e_mult);
      chk("md_ctrl_DIV", md_ctrl_DIV, e_div);
      chk("md_operandA", md_operandA, e_opa);
      chk("md_operandB", md_operandB, e_opb);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_rd", wb_rd, e_wrd);
      chk("wb_data", wb_data, e_wdata);
      chk("wb_exc", wb_exc, e_wexc);

      // observations used by the directed literal checks
      stub_pulse = md_ctrl_MULT || md_ctrl_DIV;
      stub_div = md_ctrl_DIV; stub_a = md_operandA; stub_b = md_operandB;
      if (stub_pulse) begin pulse_n++; pulse_cyc = cyc_n; pulse_a = md_operandA; pulse_b = md_operandB; end
      if (iss_ready && iss_valid && !flush) acc_cyc = cyc_n;
      if (wb_valid) wbv_n++;
      if (wb_valid && !prev_wbv) wb_first = cyc_n;
      prev_wbv = wb_valid;
      if (wb_valid && wb_ready) begin hs_n++; hs_rd = wb_rd; hs_data = wb_data; hs_exc = wb_exc; end

      // advance the model to the next cycle
      if (reset_n) begin
        if (!m_active) begin
          if (iss_valid && !flush) begin
            m_active = 1; m_age = 1; m_a = iss_a; m_b = iss_b; m_rd = iss_rd; m_div = iss_is_div;
          end
        end else if (m_have) begin
          if (wb_ready || flush) begin m_active = 0; m_have = 0; end
        end else if (m_age == 1) begin
          if (flush) m_active = 0;
          else begin m_age = 2; m_busy_n = 0; end
        end else begin
          if (flush) m_active = 0;
          else if (md_resultRDY) begin
            if (md_exception) begin
              m_have = 1; m_wrd = 5'd30; m_wdata = m_div ? 32'd5 : 32'd4; m_wexc = 1;
            end else if (m_rd == 0) m_active = 0;
            else begin m_have = 1; m_wrd = m_rd; m_wdata = md_result; m_wexc = 0; end
          end else if (m_busy_n == TIMEOUT - 1) begin
            m_have = 1; m_wrd = 5'd30; m_wdata = 32'd5; m_wexc = 1;
          end
          m_busy_n++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    while (!iss_ready && n < 200) begin cyc(); n++; end
    if (!iss_ready) begin miscompares++; vectors++; $display("FAIL issue_wait: iss_ready got 0 expected 1"); end
    iss_valid = 1; iss_is_div = div; iss_a = a; iss_b = b; iss_rd = rd;
    cyc();
    iss_valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!iss_ready && n < budget) begin cyc(); n++; end
    chk("wait_idle", iss_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, h0, w0;
    repeat (3) cyc();
    reset_n = 1;
    cyc();

    // 1: mult 7x6 -> r3, slow multdiv, wb_ready held high
    p0 = pulse_n; h0 = hs_n; stub_lat = 16; wb_ready = 1;
    issue(0, 32'd7, 32'd6, 5'd3);
    wait_idle(100);
    chk("t1_pulses", pulse_n - p0, 1);
    chk("t1_start_lat", pulse_cyc - acc_cyc, 1);
    chk("t1_hs", hs_n - h0, 1);
    chk("t1_rd", hs_rd, 3);
    chk("t1_data", hs_data, 42);
    chk("t1_exc", hs_exc, 0);

    // 2: div 100/0 -> exception redirected to r30 with code 5
    h0 = hs_n; stub_lat = 4;
    issue(1, 32'd100, 32'd0, 5'd5);
    wait_idle(100);
    chk("t2_hs", hs_n - h0, 1);
    chk("t2_rd", hs_rd, 30);
    chk("t2_data", hs_data, 5);
    chk("t2_exc", hs_exc, 1);

    // 3: writeback back-pressured for 4 cycles
    h0 = hs_n; stub_lat = 2; wb_ready = 0;
    issue(0, 32'd3, 32'd5, 5'd7);
    begin
      int n = 0;
      while (!wb_valid && n < 100) begin cyc(); n++; end
    end
    w0 = wbv_n;
    repeat (4) cyc();
    wb_ready = 1;
    cyc();
    chk("t3_idle", iss_ready, 1);
    chk("t3_wb_cycles", wbv_n - w0, 5);
    chk("t3_data", hs_data, 15);
    chk("t3_hs", hs_n - h0, 1);

    // 4: flush in BUSY, then div 9/3 -> r4
    h0 = hs_n; stub_lat = 10;
    issue(0, 32'd11, 32'd13, 5'd9);
    repeat (3) cyc();
    flush = 1; cyc(); flush = 0;
    stub_lat = 3;
    issue(1, 32'd9, 32'd3, 5'd4);
    wait_idle(100);
    chk("t4_pulse_a", pulse_a, 9);
    chk("t4_pulse_b", pulse_b, 3);
    chk("t4_hs", hs_n - h0, 1);
    chk("t4_data", hs_data, 3);
    chk("t4_rd", hs_rd, 4);

    // 5a: stale ready high at START is ignored; capture in first BUSY cycle
    stub_lat = 0;
    issue(0, 32'd2, 32'd21, 5'd6);
    wait_idle(100);
    chk("t5a_data", hs_data, 42);
    chk("t5a_wb_lat", wb_first - pulse_cyc, 2);

    // 5b: result never arrives -> timeout after 64 BUSY cycles
    stub_lat = -1;
    issue(0, 32'd1, 32'd1, 5'd8);
    wait_idle(200);
    chk("t5b_rd", hs_rd, 30);
    chk("t5b_data", hs_data, 5);
    chk("t5b_exc", hs_exc, 1);
    chk("t5b_wb_lat", wb_first - pulse_cyc, 65);

    // 6: asynchronous reset mid-BUSY
    stub_lat = 20;
    issue(1, 32'd50, 32'd7, 5'd2);
    repeat (4) cyc();
    #2 reset_n = 0;
    #1;
    chk("t6_iss_ready", iss_ready, 1);
    chk("t6_stall", stall, 0);
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_opA", md_operandA, 0);
    chk("t6_opB", md_operandB, 0);
    cyc(); cyc();
    reset_n = 1;
    h0 = hs_n; w0 = wbv_n;
    repeat (30) cyc();
    chk("t6_no_hs", hs_n - h0, 0);
    chk("t6_no_wb", wbv_n - w0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      iss_valid  = $urandom_range(0, 1);
      iss_is_div = $urandom_range(0, 1);
      iss_a      = $urandom;
      iss_b      = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      iss_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      flush      = ($urandom_range(0, 19) == 0);
      wb_ready   = ($urandom_range(0, 2) != 0);
      stub_lat   = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 5));
      stub_mexc  = ($urandom_range(0, 7) == 0);
      cyc();
    end
    iss_valid = 0; flush = 0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
